// File: rtl/optical_flow_ctrl.sv
// Purpose : sequences one frame of frame-buffer reads into the optical-flow pipeline and tags returned flow vectors.
// Latency : pix_valid/pix_sof/pix_eol one cycle after rd_en; out_valid/out_x/out_y one cycle after flow_valid_in.
// Backpressure: reads issue only on pix_ready cycles; the flow return path cannot be stalled.
// Ports   : clk/rst (async active-high); start/abort frame control; pix_ready read throttle;
//           flow_valid_in flow-vector strobe; rd_en/rd_addr frame-buffer read; pix_* read-data qualifiers;
//           out_valid/out_x/out_y flow-vector coordinate tag; busy/done/err status.
module optical_flow_ctrl #(
   parameter int IMAGE_WIDTH   = 320,
   parameter int IMAGE_HEIGHT  = 240,
   parameter int BORDER        = 4,
   parameter int ADDR_WIDTH    = 17,
   parameter int DRAIN_TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  pix_ready,
   input  logic                  flow_valid_in,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  pix_valid,
   output logic                  pix_sof,
   output logic                  pix_eol,
   output logic                  out_valid,
   output logic [15:0]           out_x,
   output logic [15:0]           out_y,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int NFLOW = (IMAGE_WIDTH - BORDER) * (IMAGE_HEIGHT - BORDER);
   localparam int DW    = $clog2(DRAIN_TIMEOUT + 1);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NPIX - 1);
   localparam logic [ADDR_WIDTH-1:0] FLOW_TOTAL = ADDR_WIDTH'(NFLOW);
   localparam logic [15:0]           COL_LAST   = 16'(IMAGE_WIDTH - 1);
   localparam logic [15:0]           TAG_START  = 16'(BORDER);
   localparam logic [DW-1:0]         DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   state_t                state;
   state_t                next_state;
   logic [15:0]           col;
   logic [15:0]           row;
   logic [15:0]           tag_x;
   logic [15:0]           tag_y;
   logic [ADDR_WIDTH-1:0] flow_cnt;
   logic [DW-1:0]         drain_cnt;
   logic                  start_frame;
   logic                  set_err;
   logic                  active;
   logic                  flow_acc;
   logic                  flow_over;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      rd_en       = 1'b0;
      start_frame = 1'b0;
      set_err     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state  = STREAM;
               start_frame = 1'b1;
            end
         end
         STREAM: begin
            busy = 1'b1;
            // abort kills the read strobe in the same cycle it is seen
            if (abort) begin
               next_state = IDLE;
               set_err    = 1'b1;
            end else begin
               rd_en = pix_ready;
               if (pix_ready && (rd_addr == LAST_ADDR)) begin
                  next_state = DRAIN;
               end
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (abort) begin
               next_state = IDLE;
               set_err    = 1'b1;
            end else if (flow_cnt == FLOW_TOTAL) begin
               next_state = DONE;
            end else if (drain_cnt == DRAIN_LAST) begin
               next_state = DONE;
               set_err    = 1'b1;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Flow vectors are only meaningful while a frame is in flight; a pulse
   // beyond the expected total means the pipeline and controller disagree.
   assign active    = ((state == STREAM) || (state == DRAIN)) && !abort;
   assign flow_acc  = active && flow_valid_in && (flow_cnt != FLOW_TOTAL);
   assign flow_over = active && flow_valid_in && (flow_cnt == FLOW_TOTAL);

   // ---------------------------------------------------------- read side
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr <= '0;
         col     <= '0;
         row     <= '0;
      end else if (start_frame) begin
         rd_addr <= '0;
         col     <= '0;
         row     <= '0;
      end else if (rd_en) begin
         // the final read leaves rd_addr parked on the last pixel
         if (rd_addr != LAST_ADDR) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
         end
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + 16'd1;
         end else begin
            col <= col + 16'd1;
         end
      end
   end

   // qualifiers line up with the BRAM data that appears one cycle after rd_en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_valid <= 1'b0;
         pix_sof   <= 1'b0;
         pix_eol   <= 1'b0;
      end else begin
         pix_valid <= rd_en;
         pix_sof   <= rd_en && (col == 16'd0) && (row == 16'd0);
         pix_eol   <= rd_en && (col == COL_LAST);
      end
   end

   // ---------------------------------------------------------- flow side
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flow_cnt  <= '0;
         tag_x     <= '0;
         tag_y     <= '0;
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
      end else begin
         out_valid <= flow_acc;
         if (start_frame) begin
            flow_cnt <= '0;
            tag_x    <= TAG_START;
            tag_y    <= TAG_START;
         end else if (flow_acc) begin
            flow_cnt <= flow_cnt + ADDR_WIDTH'(1);
            out_x    <= tag_x;
            out_y    <= tag_y;
            // valid flow starts BORDER pixels in on each line
            if (tag_x == COL_LAST) begin
               tag_x <= TAG_START;
               tag_y <= tag_y + 16'd1;
            end else begin
               tag_x <= tag_x + 16'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------- status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt <= '0;
         err       <= 1'b0;
      end else begin
         if (start_frame) begin
            drain_cnt <= '0;
         end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
         end
         if (start_frame) begin
            err <= 1'b0;
         end else if (set_err || flow_over) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_optical_flow_ctrl.sv
module tb_optical_flow_ctrl;

   localparam int W     = 8;
   localparam int H     = 6;
   localparam int B     = 4;
   localparam int NPIX  = W * H;
   localparam int NFLOW = (W - B) * (H - B);
   localparam int TMO   = 16;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic        pix_ready;
   logic        flow_valid_in;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic        pix_valid;
   logic        pix_sof;
   logic        pix_eol;
   logic        out_valid;
   logic [15:0] out_x;
   logic [15:0] out_y;
   logic        busy;
   logic        done;
   logic        err;

   int vectors;
   int miscompares;

   optical_flow_ctrl #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .BORDER(B), .ADDR_WIDTH(6), .DRAIN_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pix_ready(pix_ready),
      .flow_valid_in(flow_valid_in), .rd_en(rd_en), .rd_addr(rd_addr),
      .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // k-th flow vector of a frame, in raster order inside the border
   function automatic int tag_x_of(int k);
      return B + k % (W - B);
   endfunction
   function automatic int tag_y_of(int k);
      return B + k / (W - B);
   endfunction

   task automatic test_reset();
      logic [45:0] obs;
      rst = 1'b1; start = 1'b1; pix_ready = 1'b1; flow_valid_in = 1'b1; abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         obs = {rd_en, rd_addr, pix_valid, pix_sof, pix_eol, out_valid, out_x, out_y, busy, done, err};
         vectors++;
         if (obs !== 46'd0) begin
            miscompares++; $display("FAIL reset_outputs: got %h expected 0", obs);
         end
      end
      @(negedge clk); rst = 1'b0; start = 1'b0; flow_valid_in = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("FAIL reset_idle: got busy=%b rd_en=%b done=%b expected 000", busy, rd_en, done);
      end
      pix_ready = 1'b0;
   endtask

   task automatic test_ignore_idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); flow_valid_in = 1'b1; #1;
         if (i > 0) begin
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
               miscompares++; $display("FAIL idle_flow: got out_valid=%b busy=%b expected 0 0", out_valid, busy);
            end
         end
      end
      flow_valid_in = 1'b0;
   endtask

   // mode 0: ready always, 1: ready toggling, 2: random ready
   task automatic test_frame(input int mode, input int n_flow, input int s_flows, input bit poke, input bit extra);
      int reads, k, sent, cyc, last, exp_done, d_flows, idx, prev_addr;
      int plan [64];
      bit pr, fv, acc, prev_rd, prev_acc, exp_err;
      reads = 0; k = 0; sent = 0; cyc = 0; prev_rd = 0; prev_acc = 0; prev_addr = 0;
      @(negedge clk);
      start = 1'b1; abort = 1'b0; pix_ready = 1'b0; flow_valid_in = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL start_cycle_busy: got %b expected 0", busy);
      end
      while (reads < NPIX && cyc < 1000) begin
         @(negedge clk);
         case (mode)
            0:       pr = 1'b1;
            1:       pr = (cyc % 2 == 0);
            default: pr = 1'($urandom_range(0, 1));
         endcase
         fv = (sent < s_flows) && ($urandom_range(0, 3) == 0);
         pix_ready = pr; flow_valid_in = fv;
         start = poke && ($urandom_range(0, 5) == 0);
         #1;
         vectors++;
         if (rd_en !== pr) begin
            miscompares++; $display("FAIL stream_rd_en cyc=%0d: got %b expected %b", cyc, rd_en, pr);
         end
         vectors++;
         if (rd_addr !== reads[5:0]) begin
            miscompares++; $display("FAIL stream_rd_addr cyc=%0d: got %0d expected %0d", cyc, rd_addr, reads);
         end
         vectors++;
         if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++; $display("FAIL stream_status cyc=%0d: got busy=%b done=%b err=%b expected 1 0 0", cyc, busy, done, err);
         end
         vectors++;
         if (pix_valid !== prev_rd || pix_sof !== (prev_rd && prev_addr == 0) ||
             pix_eol !== (prev_rd && prev_addr % W == W - 1)) begin
            miscompares++;
            $display("FAIL stream_pix cyc=%0d: got v/s/e=%b%b%b expected %b%b%b", cyc, pix_valid, pix_sof, pix_eol,
                     prev_rd, prev_rd && prev_addr == 0, prev_rd && prev_addr % W == W - 1);
         end
         vectors++;
         if (out_valid !== prev_acc) begin
            miscompares++; $display("FAIL stream_out_valid cyc=%0d: got %b expected %b", cyc, out_valid, prev_acc);
         end
         if (k > 0) begin
            vectors++;
            if (out_x !== 16'(tag_x_of(k - 1)) || out_y !== 16'(tag_y_of(k - 1))) begin
               miscompares++;
               $display("FAIL stream_tag cyc=%0d: got (%0d,%0d) expected (%0d,%0d)", cyc, out_x, out_y, tag_x_of(k - 1), tag_y_of(k - 1));
            end
         end
         prev_rd = pr; prev_addr = reads;
         if (pr) reads++;
         prev_acc = fv;
         if (fv) begin sent++; k++; end
         cyc++;
      end
      vectors++;
      if (reads < NPIX) begin
         miscompares++; $display("FAIL stream_bound: got %0d reads expected %0d", reads, NPIX);
      end
      // plan drain-phase flow pulses, then derive when done must appear
      d_flows = n_flow - sent;
      foreach (plan[i]) plan[i] = 0;
      idx = 0; last = 0;
      for (int p = 0; p < d_flows; p++) begin
         plan[idx] = 1; last = idx;
         idx += 1 + ((mode == 2 && d_flows <= 5) ? int'($urandom_range(0, 1)) : 0);
      end
      if (extra) plan[last + 1] = 2;
      exp_done = (n_flow == NFLOW) ? last + 2 : TMO;
      exp_err  = (n_flow != NFLOW) || extra;
      for (idx = 0; idx <= exp_done + 1; idx++) begin
         @(negedge clk);
         fv = (plan[idx] != 0) || (poke && idx == exp_done);
         flow_valid_in = fv;
         pix_ready = 1'($urandom_range(0, 1));
         start = poke && (idx == exp_done || (idx < exp_done && $urandom_range(0, 3) == 0));
         #1;
         vectors++;
         if (rd_en !== 1'b0) begin
            miscompares++; $display("FAIL drain_rd_en idx=%0d: got %b expected 0", idx, rd_en);
         end
         vectors++;
         if (pix_valid !== prev_rd || pix_sof !== 1'b0 || pix_eol !== (prev_rd && prev_addr % W == W - 1)) begin
            miscompares++; $display("FAIL drain_pix idx=%0d: got v/s/e=%b%b%b expected %b0%b", idx, pix_valid, pix_sof, pix_eol, prev_rd, prev_rd);
         end
         vectors++;
         if (out_valid !== prev_acc) begin
            miscompares++; $display("FAIL drain_out_valid idx=%0d: got %b expected %b", idx, out_valid, prev_acc);
         end
         if (k > 0) begin
            vectors++;
            if (out_x !== 16'(tag_x_of(k - 1)) || out_y !== 16'(tag_y_of(k - 1))) begin
               miscompares++;
               $display("FAIL drain_tag idx=%0d: got (%0d,%0d) expected (%0d,%0d)", idx, out_x, out_y, tag_x_of(k - 1), tag_y_of(k - 1));
            end
         end
         vectors++;
         if (done !== (idx == exp_done) || busy !== (idx < exp_done)) begin
            miscompares++;
            $display("FAIL drain_done idx=%0d: got done=%b busy=%b expected %b %b", idx, done, busy, idx == exp_done, idx < exp_done);
         end
         vectors++;
         if (err !== ((idx >= exp_done) ? exp_err : 1'b0)) begin
            miscompares++; $display("FAIL drain_err idx=%0d: got %b expected %b", idx, err, (idx >= exp_done) ? exp_err : 1'b0);
         end
         acc = (plan[idx] == 1);
         prev_acc = acc;
         if (acc) k++;
         prev_rd = 1'b0;
      end
      start = 1'b0; flow_valid_in = 1'b0; pix_ready = 1'b0;
   endtask

   task automatic test_abort();
      int reads;
      bit hit;
      @(negedge clk); start = 1'b1; pix_ready = 1'b1; flow_valid_in = 1'b0; abort = 1'b0; #1;
      reads = 0; hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(negedge clk); start = 1'b0; abort = (reads == 20); #1;
         if (abort) begin
            hit = 1'b1;
            vectors++;
            if (rd_en !== 1'b0 || rd_addr !== 6'd20 || busy !== 1'b1) begin
               miscompares++; $display("FAIL abort_cycle: got rd_en=%b addr=%0d busy=%b expected 0 20 1", rd_en, rd_addr, busy);
            end
         end else begin
            reads++;
         end
      end
      vectors++;
      if (!hit) begin
         miscompares++; $display("FAIL abort_reach: got %0d reads expected 20", reads);
      end
      @(negedge clk); abort = 1'b0; #1;
      vectors++;
      if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0 || rd_en !== 1'b0) begin
         miscompares++; $display("FAIL abort_after: got busy=%b err=%b done=%b rd_en=%b expected 0 1 0 0", busy, err, done, rd_en);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL abort_no_done: got done=%b busy=%b expected 0 0", done, busy);
         end
      end
      @(negedge clk); start = 1'b1; #1;
      @(negedge clk); start = 1'b0; #1;
      vectors++;
      if (busy !== 1'b1 || err !== 1'b0 || rd_addr !== 6'd0 || rd_en !== 1'b1) begin
         miscompares++;
         $display("FAIL restart: got busy=%b err=%b addr=%0d rd_en=%b expected 1 0 0 1", busy, err, rd_addr, rd_en);
      end
      for (int c = 1; c < NPIX; c++) @(negedge clk);
      #1;
      vectors++;
      if (rd_addr !== 6'(NPIX - 1) || rd_en !== 1'b1) begin
         miscompares++; $display("FAIL restart_last_read: got addr=%0d rd_en=%b expected %0d 1", rd_addr, rd_en, NPIX - 1);
      end
      for (int i = 0; i <= 9; i++) begin
         @(negedge clk); flow_valid_in = (i < NFLOW); abort = (i == NFLOW); #1;
         if (i == NFLOW) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               miscompares++; $display("FAIL drain_abort_cycle: got busy=%b done=%b expected 1 0", busy, done);
            end
         end
         if (i == NFLOW + 1) begin
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
               miscompares++; $display("FAIL drain_abort_prio: got busy=%b done=%b err=%b expected 0 0 1", busy, done, err);
            end
         end
      end
      abort = 1'b0; flow_valid_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         vectors++;
         if (done !== 1'b0) begin
            miscompares++; $display("FAIL drain_abort_no_done: got %b expected 0", done);
         end
      end
      pix_ready = 1'b0;
   endtask

   task automatic test_rst_mid();
      logic [45:0] obs;
      @(negedge clk); start = 1'b1; pix_ready = 1'b1; #1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); start = 1'b0;
      end
      @(negedge clk); rst = 1'b1; #1;
      obs = {rd_en, rd_addr, pix_valid, pix_sof, pix_eol, out_valid, out_x, out_y, busy, done, err};
      vectors++;
      if (obs !== 46'd0) begin
         miscompares++; $display("FAIL rst_mid_outputs: got %h expected 0", obs);
      end
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         vectors++;
         if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_idle: got busy=%b rd_en=%b done=%b expected 000", busy, rd_en, done);
         end
      end
      pix_ready = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b0; flow_valid_in = 1'b0;
      test_reset();
      test_ignore_idle();
      test_frame(0, NFLOW, 0, 1'b0, 1'b0);
      test_frame(1, NFLOW, 0, 1'b0, 1'b0);
      test_frame(0, NFLOW - 1, 0, 1'b0, 1'b0);
      test_frame(2, NFLOW, 3, 1'b1, 1'b0);
      test_frame(2, NFLOW, 2, 1'b1, 1'b1);
      test_abort();
      test_rst_mid();
      for (int r = 0; r < 4; r++) begin
         test_frame(2, NFLOW, int'($urandom_range(0, 3)), 1'b1, r[0]);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
